// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state codes, fixed opcodes and DR selection kinds.
// Imported by the TAP controller FSM and the TAP top.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

  // Opcodes are stored 32 bits wide and truncated to the IR length at use.
  localparam logic [31:0] OPC_IDCODE   = 32'h0000_0007;
  localparam logic [31:0] OPC_BYPASS   = 32'hFFFF_FFFF;
  localparam int          IDCODE_WIDTH = 32;

  function automatic logic is_shift_state(input tap_state_t s);
    return (s == SH_DR) || (s == SH_IR);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine; advances on every rising TCK,
// returns to Test-Logic-Reset on TRST or after five TMS=1 edges.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t tap_state
);

  tap_state_t state_reg;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_reg <= TLR;
    end else begin
      case (state_reg)
        TLR:      state_reg <= TMS ? TLR    : RTI;
        RTI:      state_reg <= TMS ? SEL_DR : RTI;
        SEL_DR:   state_reg <= TMS ? SEL_IR : CAP_DR;
        CAP_DR:   state_reg <= TMS ? EX1_DR : SH_DR;
        SH_DR:    state_reg <= TMS ? EX1_DR : SH_DR;
        EX1_DR:   state_reg <= TMS ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_reg <= TMS ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_reg <= TMS ? UPD_DR : SH_DR;
        UPD_DR:   state_reg <= TMS ? SEL_DR : RTI;
        SEL_IR:   state_reg <= TMS ? TLR    : CAP_IR;
        CAP_IR:   state_reg <= TMS ? EX1_IR : SH_IR;
        SH_IR:    state_reg <= TMS ? EX1_IR : SH_IR;
        EX1_IR:   state_reg <= TMS ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_reg <= TMS ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_reg <= TMS ? UPD_IR : SH_IR;
        UPD_IR:   state_reg <= TMS ? SEL_DR : RTI;
        default:  state_reg <= TLR;
      endcase
    end
  end

  assign tap_state = state_reg;

endmodule

// File: rtl/jtag_tap_param.sv
// Parameterised JTAG TAP: instruction register, IDCODE and BYPASS registers,
// and NUM_USER user data registers with capture/update ports and strobes.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH      = 4,
  parameter int                  NUM_USER      = 2,
  parameter int                  USER_DR_WIDTH = 16,
  parameter logic [IR_WIDTH-1:0] USER_BASE     = 4'h4,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h1BEEF0A5
) (
  input  logic                              TCK,
  input  logic                              TRST,
  input  logic                              TMS,
  input  logic                              TDI,
  output logic                              TDO,
  output logic                              TDO_en,
  output logic [3:0]                        tap_state,
  output logic [IR_WIDTH-1:0]               ir_q,
  input  logic [NUM_USER*USER_DR_WIDTH-1:0] user_capture,
  output logic [NUM_USER*USER_DR_WIDTH-1:0] user_update,
  output logic [NUM_USER-1:0]               user_upd_strobe
);

  localparam int                  W          = USER_DR_WIDTH;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = OPC_IDCODE[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = OPC_BYPASS[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_t state;

  jtag_tap_fsm u_fsm (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .tap_state (state)
  );

  assign tap_state = state;

  // ---------------------------------------------------------------- IR
  logic [IR_WIDTH-1:0] ir_shift_reg;
  logic [IR_WIDTH-1:0] ir_reg;
  logic                enter_tlr;

  // The active instruction is IDCODE for the whole time spent in TLR, so it
  // is forced on the edge that enters TLR rather than the one after.
  assign enter_tlr = TMS && ((state == TLR) || (state == SEL_IR));

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift_reg <= '0;
      ir_reg       <= IR_IDCODE;
    end else begin
      case (state)
        CAP_IR:  ir_shift_reg <= IR_CAPTURE;
        SH_IR:   ir_shift_reg <= {TDI, ir_shift_reg[IR_WIDTH-1:1]};
        default: ;
      endcase
      if (state == UPD_IR) begin
        ir_reg <= ir_shift_reg;
      end else if (enter_tlr) begin
        ir_reg <= IR_IDCODE;
      end
    end
  end

  assign ir_q = ir_reg;

  // ------------------------------------------------------------ decode
  logic                is_idcode;
  logic                is_allones;
  logic [NUM_USER-1:0] user_hit;
  logic [NUM_USER-1:0] user_lsb;
  dr_sel_t             dr_sel;

  assign is_idcode  = (ir_reg == IR_IDCODE);
  assign is_allones = (ir_reg == IR_BYPASS);

  always_comb begin
    dr_sel = DR_BYPASS;
    if (is_idcode) begin
      dr_sel = DR_IDCODE;
    end else if (|user_hit) begin
      dr_sel = DR_USER;
    end
  end

  // ------------------------------------------------- IDCODE and BYPASS
  logic [IDCODE_WIDTH-1:0] idcode_sr_reg;
  logic                    bypass_reg;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      idcode_sr_reg <= '0;
      bypass_reg    <= 1'b0;
    end else begin
      case (state)
        CAP_DR: begin
          if (dr_sel == DR_IDCODE) begin
            idcode_sr_reg <= IDCODE_VALUE;
          end else if (dr_sel == DR_BYPASS) begin
            bypass_reg <= 1'b0;
          end
        end
        SH_DR: begin
          if (dr_sel == DR_IDCODE) begin
            idcode_sr_reg <= {TDI, idcode_sr_reg[IDCODE_WIDTH-1:1]};
          end else if (dr_sel == DR_BYPASS) begin
            bypass_reg <= TDI;
          end
        end
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------- user channels
  generate
    for (genvar gi = 0; gi < NUM_USER; gi++) begin : g_user
      localparam logic [IR_WIDTH-1:0] OPC_USER = USER_BASE + IR_WIDTH'(gi);

      logic [W-1:0] sr_reg;
      logic [W-1:0] sr_shift;
      logic [W-1:0] upd_reg;
      logic         strobe_reg;

      // IDCODE and all-ones win over a user opcode that happens to alias them.
      assign user_hit[gi] = (ir_reg == OPC_USER) && !is_idcode && !is_allones;

      if (W > 1) begin : g_wide
        assign sr_shift = {TDI, sr_reg[W-1:1]};
      end else begin : g_narrow
        assign sr_shift = TDI;
      end

      always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
          sr_reg     <= '0;
          upd_reg    <= '0;
          strobe_reg <= 1'b0;
        end else begin
          strobe_reg <= 1'b0;
          if (user_hit[gi]) begin
            case (state)
              CAP_DR: sr_reg <= user_capture[gi*W +: W];
              SH_DR:  sr_reg <= sr_shift;
              UPD_DR: begin
                upd_reg    <= sr_reg;
                strobe_reg <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      assign user_lsb[gi]            = sr_reg[0];
      assign user_update[gi*W +: W]  = upd_reg;
      assign user_upd_strobe[gi]     = strobe_reg;
    end
  endgenerate

  // --------------------------------------------------------- TDO path
  assign TDO_en = is_shift_state(state);

  always_comb begin
    TDO = 1'b0;
    if (state == SH_IR) begin
      TDO = ir_shift_reg[0];
    end else if (state == SH_DR) begin
      case (dr_sel)
        DR_IDCODE: TDO = idcode_sr_reg[0];
        DR_USER:   TDO = |(user_lsb & user_hit);
        default:   TDO = bypass_reg;
      endcase
    end
  end

endmodule

// File: doc/jtag_tap_param.md
JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, instruction register length (minimum 2).
REQ-002 SHALL have parameter NUM_USER, default 2, number of user data-register channels (1..8).
REQ-003 SHALL have parameter USER_DR_WIDTH, default 16, width of each user DR.
REQ-004 SHALL have parameter USER_BASE, default 4'h4, opcode of user channel 0; channel k decodes USER_BASE+k.
REQ-005 SHALL have parameter IDCODE_VALUE, default 32'h1BEEF0A5, device ID (bit 0 = 1).
REQ-006 SHALL have port TCK  input  1  TAP clock; all state changes on rising edge.
REQ-007 SHALL have port TRST  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port TMS  input  1  TAP mode select.
REQ-009 SHALL have port TDI  input  1  serial data in.
REQ-010 SHALL have port TDO  output  1  serial data out, combinational from the selected shift register LSB.
REQ-011 SHALL have port TDO_en  output  1  high only in Shift-IR or Shift-DR.
REQ-012 SHALL have port tap_state  output  4  current TAP state code.
REQ-013 SHALL have port ir_q  output  IR_WIDTH  active instruction.
REQ-014 SHALL have port user_capture  input  NUM_USER*USER_DR_WIDTH  parallel capture values, channel k at slice k.
REQ-015 SHALL have port user_update  output  NUM_USER*USER_DR_WIDTH  latched update values per channel.
REQ-016 SHALL have port user_upd_strobe  output  NUM_USER  one-TCK pulse per channel on update.

Function
REQ-017 SHALL implement the 16-state IEEE 1149.1 TAP FSM with codes TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
REQ-018 SHALL reach TLR from any state after 5 consecutive TMS=1 edges.
REQ-019 SHALL load IR shift register with {0..0,2'b01} in CapIR; shift LSB-first (TDI into MSB) in ShIR; hold in PauseIR/Exit states.
REQ-020 SHALL copy IR shift into ir_q on the rising edge taken while in UpdIR; ir_q changes at no other time except TLR/reset.
REQ-021 SHALL force ir_q to IDCODE opcode 7 (zero-extended) in TLR.
REQ-022 SHALL decode: 7 -> 32-bit IDCODE DR; all-ones -> 1-bit BYPASS; USER_BASE+k (k<NUM_USER) -> user DR k; any other opcode -> BYPASS.
REQ-023 SHALL in CapDR load the selected DR: IDCODE_VALUE, 1'b0 for BYPASS, user_capture slice k for user k.
REQ-024 SHALL in ShDR shift the selected DR LSB-first, TDI into MSB, TDO = current LSB; DR length equals the selected register width.
REQ-025 SHALL hold DR contents unchanged in PauseDR, Ex1DR, Ex2DR.
REQ-026 SHALL on the rising edge taken in UpdDR with user k selected, load user_update slice k and pulse user_upd_strobe[k] for exactly one TCK; other channels unchanged.
REQ-027 SHALL produce no strobe for IDCODE/BYPASS updates or for UpdDR entered with no user instruction.
REQ-028 SHALL make TDO 0 when TDO_en is 0.

Reset
REQ-029 SHALL on TRST asserted asynchronously set tap_state=F, ir_q=7, all shift registers 0, user_update all 0, user_upd_strobe 0, TDO_en 0.
REQ-030 SHALL on TRST mid-shift discard partial shift data and issue no update strobe.

Structure
REQ-031 SHALL place TAP state codes and opcodes IDCODE=7, BYPASS=all-ones in a shared package jtag_pkg.
REQ-032 SHALL instantiate the FSM as sub-module jtag_tap_fsm (TCK, TRST, TMS -> tap_state); register decode and shifting stay in the top.

Verification
REQ-033 SHALL test: TRST pulse from ShDR -> tap_state=F, ir_q=4'h7, TDO_en=0, strobes 0.
REQ-034 SHALL test: from PauseIR, TMS=1 x5 -> tap_state=F.
REQ-035 SHALL test: after reset go to ShDR, 32 shifts -> TDO sequence = 32'h1BEEF0A5 LSB-first.
REQ-036 SHALL test: load IR 4'h5, user_capture ch1=16'h3C3C, shift 16'hA5A5 with 4 PauseDR cycles mid-shift -> TDO outputs 16'h3C3C, user_update ch1=16'hA5A5, single strobe[1] pulse, ch0 unchanged.
REQ-037 SHALL test: IR 4'hF, shift 8'b10000001 -> TDO = 0 then input delayed one bit; IR 4'hC also behaves as BYPASS.
REQ-038 SHALL test: shift IR 4'h2 then CapIR reads 2'b01 in LSBs on TDO.
